// File: rtl/reg0_ba_gated.sv
// Register R0 with base-address gating: BaOut forces the bus-mux view to zero.
// Optional macro REG0_WRITE_FLAG_EN adds the sticky r0_written flag output.
module reg0_ba_gated #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               enable,
    input  logic [WIDTH-1:0]   input_D,
    input  logic               BaOut,
    output logic [WIDTH-1:0]   BusMuxIn_R0
`ifdef REG0_WRITE_FLAG_EN
    ,
    output logic               r0_written
`endif
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_gated;

    // Reset outranks a write arriving on the same edge.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q <= RESET_VALUE;
        end else if (enable) begin
            r_q <= input_D;
        end
    end

    // Masking only affects the bus view; writes under BaOut still land in r_q.
    always_comb begin
        w_gated = r_q;
        if (BaOut) begin
            w_gated = '0;
        end
    end

    assign BusMuxIn_R0 = w_gated;

`ifdef REG0_WRITE_FLAG_EN
    logic r_written;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_written <= 1'b0;
        end else if (enable) begin
            r_written <= 1'b1;
        end
    end

    assign r0_written = r_written;
`endif

endmodule

// File: tb/tb_reg0_ba_gated.sv
// Directed bench for reg0_ba_gated; also checks r0_written when REG0_WRITE_FLAG_EN is set.
module tb_reg0_ba_gated;

    logic        clk;
    logic        clr;
    logic        enable;
    logic [31:0] input_D;
    logic        BaOut;
    logic [31:0] BusMuxIn_R0;
`ifdef REG0_WRITE_FLAG_EN
    logic        r0_written;
`endif

    int vectors;
    int miscompares;

    reg0_ba_gated #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .enable      (enable),
        .input_D     (input_D),
        .BaOut       (BaOut),
        .BusMuxIn_R0 (BusMuxIn_R0)
`ifdef REG0_WRITE_FLAG_EN
        ,
        .r0_written  (r0_written)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOut(input string tag, input logic [31:0] expected);
        vectors++;
        assert (BusMuxIn_R0 === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, BusMuxIn_R0, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic expected);
`ifdef REG0_WRITE_FLAG_EN
        vectors++;
        assert (r0_written === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, r0_written, expected);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr     = 1'b0;
        enable  = 1'b1;
        input_D = 32'h55;
        BaOut   = 1'b0;

        tick(2);
        checkOut("reset", 32'h0);
        checkFlag("reset_flag", 1'b0);

        clr     = 1'b1;
        input_D = 32'd10;
        tick(1);
        checkOut("load10", 32'd10);
        checkFlag("flag_set", 1'b1);

        enable = 1'b0;
        BaOut  = 1'b1;
        #1;
        checkOut("ba_mask", 32'h0);
        BaOut = 1'b0;
        #1;
        checkOut("ba_release", 32'd10);

        BaOut   = 1'b1;
        enable  = 1'b1;
        input_D = 32'd20;
        tick(1);
        checkOut("hidden_write", 32'h0);
        enable = 1'b0;
        BaOut  = 1'b0;
        #1;
        checkOut("hidden_reveal", 32'd20);

        input_D = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOut("hold", 32'd20);
        end

        input_D = 'x;
        tick(1);
        checkOut("hold_x", 32'd20);

        enable  = 1'b1;
        input_D = 32'hA5A5_5A5A;
        tick(1);
        checkOut("load_pattern", 32'hA5A5_5A5A);
        input_D = 32'h5A5A_A5A5;
        tick(1);
        checkOut("load_inverse", 32'h5A5A_A5A5);
        input_D = 32'd20;
        tick(1);
        checkOut("load20", 32'd20);

        clr     = 1'b0;
        enable  = 1'b1;
        input_D = 32'd30;
        tick(1);
        checkOut("reset_priority", 32'h0);
        checkFlag("reset_clears_flag", 1'b0);

        clr     = 1'b1;
        enable  = 1'b0;
        input_D = 32'd40;
        BaOut   = 1'b1;
        tick(1);
        checkOut("idle_masked", 32'h0);
        checkFlag("flag_stays_clear", 1'b0);
        BaOut = 1'b0;
        #1;
        checkOut("idle_unmasked", 32'h0);

        enable  = 1'b1;
        BaOut   = 1'b1;
        input_D = 32'h0000_0077;
        tick(1);
        checkFlag("flag_under_ba", 1'b1);
        enable  = 1'b0;
        BaOut   = 1'b0;
        #1;
        checkOut("final_reveal", 32'h0000_0077);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
